// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: state encoding, default
// parameter values and the key_code width helper.
// Optional feature macro: KEYPAD_SCAN_CTRL_REPEAT_EN (auto-repeat on a held key).
package keypad_pkg;

  localparam int DEF_ROWS         = 4;
  localparam int DEF_COLS         = 4;
  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_DEBOUNCE     = 4;
  localparam int DEF_REPEAT_DELAY = 100;
  localparam int DEF_REPEAT_RATE  = 25;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_DEBOUNCE = 3'd2,
    ST_PRESSED  = 3'd3,
    ST_RELEASE  = 3'd4
  } kp_state_e;

  // Width of key_code; a 1x1 keypad still gets a 1-bit port.
  function automatic int key_code_width(input int rows, input int cols);
    int n;
    n = rows * cols;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider: one-clk tick every DIV clk cycles.
module keypad_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV <= 2) ? 1 : $clog2(DIV);

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  // Count 0..DIV-1 and flag the wrap as the tick.
  // NOTE: sequential state uses <= so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner with debounce on press and release.
// Columns are driven one-cold, rows are active-low inputs with pull-ups.
// Optional feature macro: KEYPAD_SCAN_CTRL_REPEAT_EN adds auto-repeat
// pulses on key_press while a key stays held.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int DEBOUNCE     = DEF_DEBOUNCE,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [ROWS-1:0]                        row,
  output logic [COLS-1:0]                        col,
  output logic [key_code_width(ROWS, COLS)-1:0]  key_code,
  output logic                                   key_valid,
  output logic                                   key_press,
  output logic                                   key_release
);

  localparam int KW  = key_code_width(ROWS, COLS);
  localparam int CIW = (COLS <= 1) ? 1 : $clog2(COLS);
  localparam int RIW = (ROWS <= 1) ? 1 : $clog2(ROWS);
  localparam int DW  = cnt_width(DEBOUNCE);

  if (ROWS < 1 || ROWS > 8 || COLS < 1 || COLS > 8 || TICK_DIV < 2 ||
      DEBOUNCE < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("keypad_scan_ctrl: parameter out of range");
  end

  kp_state_e       state_q;
  logic [COLS-1:0] col_q;
  logic [CIW-1:0]  col_idx_q;
  logic [ROWS-1:0] cap_row_q;
  logic [DW-1:0]   deb_cnt_q;
  logic [KW-1:0]   key_code_q;
  logic            key_valid_q;
  logic            key_press_q;
  logic            key_release_q;

  logic [ROWS-1:0] row_meta_q;
  logic [ROWS-1:0] row_sync_q;
  logic            tick;
  logic            row_idle;
  logic [RIW-1:0]  hit_row;
  logic [KW-1:0]   hit_code;
  logic            rpt_fire;

  // Drive only column idx low, every other column released.
  function automatic logic [COLS-1:0] one_cold(input logic [CIW-1:0] idx);
    logic [COLS-1:0] v;
    v      = '1;
    v[idx] = 1'b0;
    return v;
  endfunction

  keypad_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Two-flop synchronizer on the asynchronous row inputs.
  // NOTE: reset to all ones (the pulled-up idle level) so leaving reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  assign row_idle = &row_sync_q;

  // Lowest low row of the captured pattern wins when several are pressed.
  // NOTE: default assignment first keeps this purely combinational (no latch).
  always_comb begin
    hit_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!cap_row_q[r]) hit_row = RIW'(r);
    end
  end

  assign hit_code = KW'(col_idx_q) * KW'(ROWS) + KW'(hit_row);

`ifdef KEYPAD_SCAN_CTRL_REPEAT_EN
  localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);

  logic [RW-1:0] rpt_cnt_q;
  logic          rpt_first_q;
  logic [RW-1:0] rpt_last;

  assign rpt_last = rpt_first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1);
  assign rpt_fire = tick && (state_q == ST_PRESSED) && !row_idle && (rpt_cnt_q == rpt_last);

  // Ticks since the last press pulse; cleared whenever PRESSED is left,
  // so a return from RELEASE restarts the initial delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else if (state_q != ST_PRESSED) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else if (tick && !row_idle) begin
      if (rpt_cnt_q == rpt_last) begin
        rpt_cnt_q   <= '0;
        rpt_first_q <= 1'b0;
      end else begin
        rpt_cnt_q <= rpt_cnt_q + RW'(1);
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Scan state machine; advances on ticks only, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      col_q         <= '0;
      col_idx_q     <= '0;
      cap_row_q     <= '1;
      deb_cnt_q     <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      if (tick) begin
        case (state_q)
          ST_IDLE: begin
            col_q <= '0;
            if (!row_idle) begin
              state_q   <= ST_SCAN;
              col_idx_q <= '0;
              col_q     <= one_cold('0);
            end
          end
          ST_SCAN: begin
            if (!row_idle) begin
              // Column stays driven; col_idx_q now names the hit column.
              cap_row_q <= row_sync_q;
              deb_cnt_q <= '0;
              state_q   <= ST_DEBOUNCE;
            end else if (col_idx_q == CIW'(COLS - 1)) begin
              state_q <= ST_IDLE;
              col_q   <= '0;
            end else begin
              col_idx_q <= col_idx_q + CIW'(1);
              col_q     <= one_cold(col_idx_q + CIW'(1));
            end
          end
          ST_DEBOUNCE: begin
            if (row_sync_q != cap_row_q) begin
              state_q <= ST_IDLE;
              col_q   <= '0;
            end else if (deb_cnt_q == DW'(DEBOUNCE - 1)) begin
              state_q     <= ST_PRESSED;
              key_code_q  <= hit_code;
              key_valid_q <= 1'b1;
              key_press_q <= 1'b1;
            end else begin
              deb_cnt_q <= deb_cnt_q + DW'(1);
            end
          end
          ST_PRESSED: begin
            if (row_idle) begin
              state_q   <= ST_RELEASE;
              deb_cnt_q <= '0;
            end else if (rpt_fire) begin
              key_press_q <= 1'b1;
            end
          end
          ST_RELEASE: begin
            if (!row_idle) begin
              state_q <= ST_PRESSED;
            end else if (deb_cnt_q == DW'(DEBOUNCE - 1)) begin
              state_q       <= ST_IDLE;
              col_q         <= '0;
              key_valid_q   <= 1'b0;
              key_release_q <= 1'b1;
            end else begin
              deb_cnt_q <= deb_cnt_q + DW'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            col_q   <= '0;
          end
        endcase
      end
    end
  end

  assign col         = col_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural key matrix.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_keypad_scan_ctrl;

  localparam int ROWS         = 4;
  localparam int COLS         = 4;
  localparam int TICK_DIV     = 4;
  localparam int DEBOUNCE     = 3;
  localparam int REPEAT_DELAY = 6;
  localparam int REPEAT_RATE  = 2;
  localparam int KW           = 4;
  localparam int MAX_LAT      = (COLS + DEBOUNCE + 2) * TICK_DIV + 3;  // 39 clk

`ifdef KEYPAD_SCAN_CTRL_REPEAT_EN
  localparam int EXP_RPT = 5;   // repeats at ticks 6, 8, 10, 12, 14
`else
  localparam int EXP_RPT = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [ROWS-1:0]      row;
  logic [COLS-1:0]      col;
  logic [KW-1:0]        key_code;
  logic                 key_valid;
  logic                 key_press;
  logic                 key_release;
  logic [ROWS*COLS-1:0] keys = '0;   // bit c*ROWS+r = key at col c, row r held

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Key matrix: a held key pulls its row low while its column is driven low.
  always_comb begin
    row = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (keys[c*ROWS + r] && (col[c] === 1'b0)) row[r] = 1'b0;
  end

  keypad_scan_ctrl #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .TICK_DIV     (TICK_DIV),
    .DEBOUNCE     (DEBOUNCE),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_press   (key_press),
    .key_release (key_release)
  );

  // Waits up to limit falling edges for key_press (rel=0) or key_release (rel=1).
  task automatic wait_pulse(input bit rel, input int limit, output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= limit && !seen; i++) begin
      @(negedge clk);
      if ((rel ? key_release : key_press) === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    keys  = '0;
    repeat (2) @(negedge clk);
    checks++; if (col !== 4'b0000) begin errors++; $display("FAIL reset_col: got %b want 0000", col); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", key_code); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    checks++; if (key_press !== 1'b0 || key_release !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got press=%b release=%b want 0 0", key_press, key_release);
    end
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (col !== 4'b0000 || key_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got col=%b valid=%b want 0000 0", col, key_valid);
    end
  endtask

  task automatic test_clean_press();
    int lat, rl, presses, early, rel_seen, drops;
    bit seen;
    keys[9] = 1'b1;  // col 2, row 1
    wait_pulse(1'b0, 60, lat, seen);
    checks++; if (!seen) begin errors++; $display("FAIL press_seen: got none want key_press within 60 clk"); end
    checks++; if (lat > MAX_LAT) begin errors++; $display("FAIL press_latency_max: got %0d want <= %0d", lat, MAX_LAT); end
    // IDLE detect (edge 3..6), scan cols 0,1,2 then 3 debounce ticks: 6 ticks later.
    checks++; if (lat < 27 || lat > 30) begin errors++; $display("FAIL press_latency_window: got %0d want 27..30", lat); end
    checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL press_code: got %0d want 9", key_code); end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL press_valid: got %b want 1", key_valid); end
    presses = seen ? 1 : 0;
    early = 0; rel_seen = 0; drops = 0;
    for (int i = lat + 1; i <= 40 * TICK_DIV; i++) begin
      @(negedge clk);
      if (key_press === 1'b1) begin
        presses++;
        if (i <= lat + 5 * TICK_DIV) early++;
      end
      if (key_release === 1'b1) rel_seen++;
      if (key_valid !== 1'b1) drops++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL press_single_pulse: got %0d extra pulses want 0", early); end
`ifndef KEYPAD_SCAN_CTRL_REPEAT_EN
    checks++; if (presses != 1) begin errors++; $display("FAIL press_count_hold: got %0d want 1", presses); end
`endif
    checks++; if (rel_seen != 0 || drops != 0) begin
      errors++; $display("FAIL press_hold_stable: got release=%0d valid_drops=%0d want 0 0", rel_seen, drops);
    end
    keys = '0;
    wait_pulse(1'b1, 40, rl, seen);
    // PRESSED sees the release at edge 3..6, then 3 more debounce ticks.
    checks++; if (!seen || rl < 15 || rl > 18) begin
      errors++; $display("FAIL release_latency: got seen=%b lat=%0d want 15..18", seen, rl);
    end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b want 0", key_valid); end
    @(negedge clk);
    checks++; if (key_release !== 1'b0) begin errors++; $display("FAIL release_one_clk: got %b want 0", key_release); end
    checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL release_code_hold: got %0d want 9", key_code); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_bounce();
    int presses, valids;
    presses = 0; valids = 0;
    for (int i = 0; i < 100; i++) begin
      keys[6] = (i < 4) || (i >= 8 && i < 12);  // col 1, row 2: toggles each tick
      @(negedge clk);
      if (key_press === 1'b1) presses++;
      if (key_valid === 1'b1) valids++;
    end
    checks++; if (presses != 0) begin errors++; $display("FAIL bounce_press: got %0d want 0", presses); end
    checks++; if (valids != 0) begin errors++; $display("FAIL bounce_valid: got %0d clk high want 0", valids); end
    checks++; if (col !== 4'b0000) begin errors++; $display("FAIL bounce_idle: got col=%b want 0000", col); end
  endtask

  task automatic test_two_keys();
    int lat, presses;
    bit seen;
    keys[12] = 1'b1;  // col 3, row 0
    keys[15] = 1'b1;  // col 3, row 3
    wait_pulse(1'b0, 60, lat, seen);
    checks++; if (!seen || key_code !== 4'd12) begin
      errors++; $display("FAIL two_rows_code: got seen=%b code=%0d want 12", seen, key_code);
    end
    keys[2] = 1'b1;   // col 0, row 2 while the first key is held
    presses = 0;
    repeat (20) begin
      @(negedge clk);
      if (key_press === 1'b1) presses++;
    end
    checks++; if (presses != 0) begin errors++; $display("FAIL second_key_press: got %0d want 0", presses); end
    checks++; if (key_code !== 4'd12 || key_valid !== 1'b1) begin
      errors++; $display("FAIL second_key_hold: got code=%0d valid=%b want 12 1", key_code, key_valid);
    end
    keys = '0;
    wait_pulse(1'b1, 40, lat, seen);
    checks++; if (!seen) begin errors++; $display("FAIL two_keys_release: got none want key_release within 40 clk"); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_glitch();
    int lat, presses, rels, drops;
    bit seen;
    keys[5] = 1'b1;  // col 1, row 1
    wait_pulse(1'b0, 60, lat, seen);
    checks++; if (!seen) begin errors++; $display("FAIL glitch_press: got none want key_press within 60 clk"); end
    keys[5] = 1'b0;  // released for exactly one tick period
    presses = 0; rels = 0; drops = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == TICK_DIV) keys[5] = 1'b1;
      if (key_press === 1'b1) presses++;
      if (key_release === 1'b1) rels++;
      if (key_valid !== 1'b1) drops++;
    end
    checks++; if (rels != 0) begin errors++; $display("FAIL glitch_release: got %0d want 0", rels); end
    checks++; if (presses != 0) begin errors++; $display("FAIL glitch_press_again: got %0d want 0", presses); end
    checks++; if (drops != 0) begin errors++; $display("FAIL glitch_valid: got %0d clk low want 0", drops); end
    keys = '0;
    wait_pulse(1'b1, 40, lat, seen);
    checks++; if (!seen) begin errors++; $display("FAIL glitch_final_release: got none want key_release"); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_press();
    int lat, rels;
    bit seen;
    keys[14] = 1'b1;  // col 3, row 2
    wait_pulse(1'b0, 60, lat, seen);
    checks++; if (!seen || key_valid !== 1'b1) begin
      errors++; $display("FAIL rst_press_before: got seen=%b valid=%b want 1 1", seen, key_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({col, key_code, key_valid, key_press, key_release} !== '0) begin
      errors++; $display("FAIL rst_outputs: got col=%b code=%0d valid=%b press=%b release=%b want all 0",
                        col, key_code, key_valid, key_press, key_release);
    end
    rels = 0;
    repeat (3) begin
      @(negedge clk);
      if (key_release === 1'b1) rels++;
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 60 && key_press !== 1'b1; i++) begin
      @(negedge clk);
      if (key_release === 1'b1) rels++;
      lat = i;
    end
    checks++; if (rels != 0) begin errors++; $display("FAIL rst_no_release: got %0d want 0", rels); end
    checks++; if (key_press !== 1'b1 || lat > MAX_LAT) begin
      errors++; $display("FAIL rst_repress: got press=%b lat=%0d want 1 within %0d", key_press, lat, MAX_LAT);
    end
    checks++; if (key_code !== 4'd14) begin errors++; $display("FAIL rst_repress_code: got %0d want 14", key_code); end
    keys = '0;
    wait_pulse(1'b1, 40, lat, seen);
    checks++; if (!seen) begin errors++; $display("FAIL rst_final_release: got none want key_release"); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_repeat();
    int lat, n;
    int offs[8];
    bit seen;
    keys[7] = 1'b1;  // col 1, row 3
    wait_pulse(1'b0, 60, lat, seen);
    checks++; if (!seen || key_code !== 4'd7) begin
      errors++; $display("FAIL repeat_first: got seen=%b code=%0d want 1 7", seen, key_code);
    end
    n = 0;
    for (int i = 1; i <= 14 * TICK_DIV + 4; i++) begin
      @(negedge clk);
      if (key_press === 1'b1) begin
        if (n < 8) offs[n] = i;
        n++;
      end
    end
    checks++; if (n != EXP_RPT) begin errors++; $display("FAIL repeat_count: got %0d want %0d", n, EXP_RPT); end
    for (int j = 0; j < EXP_RPT && j < n; j++) begin
      checks++;
      if (offs[j] != (REPEAT_DELAY + j * REPEAT_RATE) * TICK_DIV) begin
        errors++; $display("FAIL repeat_offset_%0d: got %0d want %0d", j, offs[j],
                          (REPEAT_DELAY + j * REPEAT_RATE) * TICK_DIV);
      end
    end
    keys = '0;
    wait_pulse(1'b1, 40, lat, seen);
    checks++; if (!seen) begin errors++; $display("FAIL repeat_release: got none want key_release"); end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_two_keys();
    test_glitch();
    test_reset_mid_press();
    test_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
